// File: rtl/mac2_seq_ctrl_if.sv
// Handshake bundle for mac2_seq_ctrl.
//   start/cfg_len          : job launch pulse and beat count (sampled in IDLE)
//   busy                   : sequencer not idle
//   in_valid/in_ready/in_data   : operand beat stream, in_data = {w1,a1,w0,a0}
//   out_valid/out_ready/out_sum/out_ovf : one signed result per job
// master: the side that launches jobs and feeds beats; slave: the sequencer.
interface mac2_seq_ctrl_if #(
  parameter int unsigned LEN_W = 7,
  parameter int unsigned ACC_W = 16
);
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output start, cfg_len, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  start, cfg_len, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mac2_seq_ctrl.sv
// mac2_seq_ctrl: streams packed 2-bit activation/weight beats through a
// muladd2 lookup and accumulates the signed dot product over cfg_len beats,
// returning one result per job over a valid/ready handshake.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset, honoured in every state
//   bus    : mac2_seq_ctrl_if.slave (start/cfg_len/busy, in_* beat stream,
//            out_* result handshake)
//
// Build option: define MAC2_SAT_EN to clamp the accumulator to the signed
// ACC_W range and report clamping on out_ovf (sticky per job). Without it the
// accumulator wraps and out_ovf is tied low.
//
// Codes decode 00->-3, 01->-1, 10->+1, 11->+3; a beat adds a0*w0 + a1*w1.
// ACC_W must be at least 6 so that a single step (-18..+18) fits.
module mac2_seq_ctrl #(
  parameter int unsigned LEN_W = 7,
  parameter int unsigned ACC_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  mac2_seq_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       p_data_q, p_data_d;
  logic             p_vld_q, p_vld_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Signed product of two 2-bit codes; magnitude is 3 for 00/11, 1 for 01/10.
  function automatic logic signed [5:0] prod2(input logic [1:0] a, input logic [1:0] w);
    logic [5:0] mag;
    unique case ({a[1] ~^ a[0], w[1] ~^ w[0]})
      2'b00:        mag = 6'd1;
      2'b01, 2'b10: mag = 6'd3;
      default:      mag = 6'd9;
    endcase
    prod2 = (a[1] ^ w[1]) ? -$signed(mag) : $signed(mag);
  endfunction

  // muladd2 lookup: unsigned L = (a0*w0 + a1*w1 + 18) / 2, range 0..18.
  // The sum of two odd products is always even, so the halving is exact.
  function automatic logic [4:0] muladd2_lut(input logic [7:0] d);
    logic [5:0] biased;
    biased = prod2(d[1:0], d[3:2]) + prod2(d[5:4], d[7:6]) + 6'd18;
    muladd2_lut = 5'(biased >> 1);
  endfunction

  logic [4:0]       lut_l;
  logic [6:0]       step7;
  logic [ACC_W-1:0] step_ext;
  logic [ACC_W-1:0] acc_next;

  assign lut_l    = muladd2_lut(p_data_q);
  assign step7    = {1'b0, lut_l, 1'b0} - 7'd18;   // 2*L - 18
  assign step_ext = ACC_W'($signed(step7));

`ifdef MAC2_SAT_EN
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_w;
  logic             sat_hit;

  // One guard bit detects signed overflow; clamp toward the sign of the
  // true (unbounded) sum.
  assign sum_w   = {acc_q[ACC_W-1], acc_q} + {step_ext[ACC_W-1], step_ext};
  assign sat_hit = sum_w[ACC_W] ^ sum_w[ACC_W-1];
  assign acc_next = !sat_hit     ? sum_w[ACC_W-1:0] :
                    sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                   {1'b0, {(ACC_W-1){1'b1}}};
  assign bus.out_ovf = ovf_q;
`else
  assign acc_next    = acc_q + step_ext;
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = (state_q == StRun) && (cnt_q != len_q);
  assign bus.out_valid = (state_q == StOut);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_sum   = acc_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    p_data_d = p_data_q;
    p_vld_d  = 1'b0;
    acc_d    = acc_q;
`ifdef MAC2_SAT_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d   = bus.cfg_len;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef MAC2_SAT_EN
          ovf_d   = 1'b0;
`endif
          // A zero-length job has nothing to stream; report 0 straight away.
          state_d = (bus.cfg_len == '0) ? StOut : StRun;
        end
      end
      StRun: begin
        if (bus.in_valid && bus.in_ready) begin
          p_data_d = bus.in_data;
          p_vld_d  = 1'b1;
          cnt_d    = cnt_q + LEN_W'(1);
        end
        if (p_vld_q) begin
          acc_d = acc_next;
`ifdef MAC2_SAT_EN
          ovf_d = ovf_q | sat_hit;
`endif
          // Last beat is in the pipeline stage: its accumulate lands now.
          if (cnt_q == len_q) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      p_data_q <= '0;
      p_vld_q  <= 1'b0;
      acc_q    <= '0;
`ifdef MAC2_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      p_data_q <= p_data_d;
      p_vld_q  <= p_vld_d;
      acc_q    <= acc_d;
`ifdef MAC2_SAT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule
